// File: rtl/csr_led_pwm.sv
// csr_led_pwm: CSR-mapped PWM/blink driver for the board LED.
// CTRL (at Addr) holds en, inv and prescale. DUTY (at Addr+1) holds the staged duty and period.
// A prescaled free-running counter is compared against a shadow copy of duty/period.
// The shadow copy reloads at each period wrap, so a DUTY write never cuts a period short.
// csr_op uses the RISC-V funct3 encoding. Other encodings read but do not write.
module csr_led_pwm #(
   parameter logic [11:0] Addr          = 12'h001,
   parameter int unsigned PwmWidth      = 8,
   parameter int unsigned PrescaleWidth = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_enable,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  rs1_zimm,
   input  logic [31:0] rs1_data,
   input  logic [2:0]  csr_op,
   output logic [31:0] out,
   output logic        led
);

   typedef enum logic [2:0] {
      CSRRW  = 3'b001,
      CSRRS  = 3'b010,
      CSRRC  = 3'b011,
      CSRRWI = 3'b101,
      CSRRSI = 3'b110,
      CSRRCI = 3'b111
   } csr_op_t;

   localparam logic [11:0]              DutyAddr = Addr + 12'd1;
   localparam logic [PwmWidth-1:0]      CntOne   = PwmWidth'(1);
   localparam logic [PrescaleWidth-1:0] PreOne   = PrescaleWidth'(1);

   // Architectural state
   logic                     en;
   logic                     inv;
   logic [PrescaleWidth-1:0] prescale;
   logic [PwmWidth-1:0]      duty;
   logic [PwmWidth-1:0]      period;
   logic [PwmWidth-1:0]      duty_sh;
   logic [PwmWidth-1:0]      period_sh;
   logic [PrescaleWidth-1:0] pre_cnt;
   logic [PwmWidth-1:0]      cnt;

   // Decode and control
   logic        sel_ctrl;
   logic        sel_duty;
   logic        wr_valid;
   logic        wr_ctrl;
   logic        wr_duty;
   logic        en_next;
   logic        run;
   logic        tick;
   logic        wrap;
   logic [31:0] ctrl_rd;
   logic [31:0] duty_rd;
   logic [31:0] old_val;
   logic [31:0] src;
   logic [31:0] wdata;

   // Bits of wdata outside the defined fields are intentionally dropped on write.
   logic [31:0] unused_wdata;
   assign unused_wdata = wdata;

   // Decode the CSR access, form the read value and the read-modify-write result
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
      sel_ctrl = csr_enable && (csr_addr == Addr);
      sel_duty = csr_enable && (csr_addr == DutyAddr);

      ctrl_rd                       = '0;
      ctrl_rd[0]                    = en;
      ctrl_rd[1]                    = inv;
      ctrl_rd[8 +: PrescaleWidth]   = prescale;

      duty_rd                       = '0;
      duty_rd[0 +: PwmWidth]        = duty;
      duty_rd[PwmWidth +: PwmWidth] = period;

      old_val = sel_ctrl ? ctrl_rd : (sel_duty ? duty_rd : '0);
      src     = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

      wr_valid = 1'b1;
      wdata    = old_val;
      case (csr_op)
         CSRRW, CSRRWI: wdata = src;
         CSRRS, CSRRSI: wdata = old_val | src;
         CSRRC, CSRRCI: wdata = old_val & ~src;
         default:       wr_valid = 1'b0;
      endcase

      wr_ctrl = sel_ctrl && wr_valid;
      wr_duty = sel_duty && wr_valid;

      // Counting runs only while en is set both before and after this edge.
      // Enabling therefore starts from zero one cycle later, and disabling zeroes the counters at once.
      en_next = wr_ctrl ? wdata[0] : en;
      run     = en && en_next;
      tick    = (pre_cnt == prescale);
      wrap    = tick && (cnt == period_sh);
   end

   assign out = old_val;

   // CSR-visible CTRL fields and DUTY staging registers
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments, so every block sees pre-edge values at the edge.
      if (reset) begin
         en       <= 1'b0;
         inv      <= 1'b0;
         prescale <= '0;
         duty     <= '0;
         period   <= '0;
      end else begin
         if (wr_ctrl) begin
            en       <= wdata[0];
            inv      <= wdata[1];
            prescale <= wdata[8 +: PrescaleWidth];
         end
         if (wr_duty) begin
            duty   <= wdata[0 +: PwmWidth];
            period <= wdata[PwmWidth +: PwmWidth];
         end
      end
   end

   // Prescaler, PWM counter and shadow duty/period (shadows load pre-write staging values)
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt   <= '0;
         cnt       <= '0;
         duty_sh   <= '0;
         period_sh <= '0;
      end else if (run) begin
         if (tick) begin
            pre_cnt <= '0;
            if (wrap) begin
               cnt       <= '0;
               duty_sh   <= duty;
               period_sh <= period;
            end else begin
               cnt <= cnt + CntOne;
            end
         end else begin
            pre_cnt <= pre_cnt + PreOne;
         end
      end else begin
         pre_cnt   <= '0;
         cnt       <= '0;
         duty_sh   <= duty;
         period_sh <= period;
      end
   end

   // Registered LED from the pre-edge counter, so led trails cnt by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         led <= 1'b0;
      end else begin
         led <= en & ((cnt < duty_sh) ^ inv);
      end
   end

endmodule

// File: tb/tb_csr_led_pwm.sv
// tb_csr_led_pwm: directed plus randomized bench for csr_led_pwm.
// The reference model tracks the LED as a position within the current period, measured in clock cycles.
// It reloads the shadow duty/period when that position reaches (period+1)*(prescale+1).
module tb_csr_led_pwm;

   localparam logic [11:0] CtrlAddr = 12'h001;
   localparam logic [11:0] DutyAddr = 12'h002;
   localparam logic [2:0]  OpRw  = 3'b001;
   localparam logic [2:0]  OpRs  = 3'b010;
   localparam logic [2:0]  OpRc  = 3'b011;
   localparam logic [2:0]  OpRwi = 3'b101;
   localparam logic [2:0]  OpRsi = 3'b110;
   localparam logic [2:0]  OpRci = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        csr_enable;
   logic [11:0] csr_addr;
   logic [4:0]  rs1_zimm;
   logic [31:0] rs1_data;
   logic [2:0]  csr_op;
   logic [31:0] out;
   logic        led;

   always #5 clk = ~clk;

   csr_led_pwm #(.Addr(CtrlAddr), .PwmWidth(8), .PrescaleWidth(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .csr_enable (csr_enable),
      .csr_addr   (csr_addr),
      .rs1_zimm   (rs1_zimm),
      .rs1_data   (rs1_data),
      .csr_op     (csr_op),
      .out        (out),
      .led        (led)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: CSR fields, shadows and the cycle position inside the current period
   int m_en, m_inv, m_prescale, m_duty, m_period;
   int m_duty_sh, m_period_sh, m_phase, m_led;

   function automatic int model_read(input logic en, input logic [11:0] a);
      if (!en)           return 0;
      if (a == CtrlAddr) return (m_prescale << 8) | (m_inv << 1) | m_en;
      if (a == DutyAddr) return (m_period << 8) | m_duty;
      return 0;
   endfunction

   task automatic model_edge();
      int old, src, nv, len, led_next, en_after;
      bit hit_c, hit_d, do_wr;
      if (reset) begin
         m_en = 0; m_inv = 0; m_prescale = 0; m_duty = 0; m_period = 0;
         m_duty_sh = 0; m_period_sh = 0; m_phase = 0; m_led = 0;
         return;
      end
      hit_c = csr_enable && (csr_addr == CtrlAddr);
      hit_d = csr_enable && (csr_addr == DutyAddr);
      old   = model_read(csr_enable, csr_addr);
      src   = csr_op[2] ? int'(rs1_zimm) : int'(rs1_data);
      do_wr = 1'b1;
      case (csr_op)
         OpRw, OpRwi: nv = src;
         OpRs, OpRsi: nv = old | src;
         OpRc, OpRci: nv = old & ~src;
         default: begin nv = old; do_wr = 1'b0; end
      endcase
      en_after = (hit_c && do_wr) ? (nv & 1) : m_en;

      // LED level: which prescaled step of the period we are in, versus duty
      led_next = (m_en != 0 && (((m_phase / (m_prescale + 1)) < m_duty_sh) != (m_inv != 0))) ? 1 : 0;
      len      = (m_period_sh + 1) * (m_prescale + 1);
      if (m_en != 0 && en_after != 0) begin
         m_phase++;
         if (m_phase == len) begin
            m_phase     = 0;
            m_duty_sh   = m_duty;
            m_period_sh = m_period;
         end
      end else begin
         m_phase     = 0;
         m_duty_sh   = m_duty;
         m_period_sh = m_period;
      end
      m_led = led_next;

      if (do_wr && hit_c) begin
         m_en       = nv & 1;
         m_inv      = (nv >> 1) & 1;
         m_prescale = (nv >> 8) & 255;
      end
      if (do_wr && hit_d) begin
         m_duty   = nv & 255;
         m_period = (nv >> 8) & 255;
      end
   endtask

   // One clock cycle: drive on the falling edge, check out, then check led after the rising edge
   task automatic cyc(input bit rst, input bit en, input logic [11:0] a, input logic [2:0] op,
                      input logic [31:0] d, input logic [4:0] z, output logic [31:0] rd);
      @(negedge clk);
      reset = rst; csr_enable = en; csr_addr = a; csr_op = op; rs1_data = d; rs1_zimm = z;
      #1;
      rd = out;
      check("out", out, model_read(en, a));
      @(posedge clk);
      model_edge();
      #1;
      check("led", {31'd0, led}, m_led);
   endtask

   logic [31:0] rd;
   logic [31:0] rd_dummy;

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 12'h000, 3'b000, 32'd0, 5'd0, rd_dummy);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] v);
      cyc(1'b0, 1'b1, a, OpRw, v, 5'd0, rd_dummy);
   endtask

   // Idle n cycles and compare led with a fixed pattern, bit i after the i-th edge
   task automatic expect_led(input string tag, input logic [31:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         idle(1);
         check(tag, {31'd0, led}, {31'd0, pat[i]});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   logic [2:0]  ops [6];
   logic [11:0] others [4];
   int unsigned sel;
   logic [31:0] r;
   logic [31:0] v;
   logic [4:0]  z;
   logic [2:0]  op;

   initial begin
      ops    = '{OpRw, OpRs, OpRc, OpRwi, OpRsi, OpRci};
      others = '{12'h000, 12'h003, 12'h7ff, 12'h301};
      reset = 1'b1; csr_enable = 1'b0; csr_addr = '0; csr_op = '0; rs1_data = '0; rs1_zimm = '0;
      cyc(1'b1, 1'b0, 12'h000, 3'b000, 32'd0, 5'd0, rd);
      cyc(1'b1, 1'b0, 12'h000, 3'b000, 32'd0, 5'd0, rd);

      // Reset values read back as zero and the LED stays dark
      cyc(1'b0, 1'b1, CtrlAddr, OpRs, 32'd0, 5'd0, rd);
      check("rd_ctrl_rst", rd, 32'd0);
      cyc(1'b0, 1'b1, DutyAddr, OpRs, 32'd0, 5'd0, rd);
      check("rd_duty_rst", rd, 32'd0);
      expect_led("led_rst_idle", 32'h0, 20);

      // period 3, duty 1: 1,0,0,0 starting the edge after enable
      wr(DutyAddr, 32'h0000_0301);
      wr(CtrlAddr, 32'h1);
      expect_led("pat_p3_d1", 32'h11, 8);
      cyc(1'b0, 1'b1, CtrlAddr, OpRs, 32'd0, 5'd0, rd);
      check("rd_ctrl_en", rd, 32'h1);
      cyc(1'b0, 1'b1, DutyAddr, OpRs, 32'd0, 5'd0, rd);
      check("rd_duty", rd, 32'h0301);

      // prescale 1 doubles every level
      wr(CtrlAddr, 32'h0);
      wr(CtrlAddr, 32'h101);
      expect_led("pat_pre1", 32'h0303, 16);

      // Mid-period DUTY write takes effect at the next wrap; a write on the wrap edge waits a period
      wr(CtrlAddr, 32'h0);
      wr(CtrlAddr, 32'h1);
      expect_led("pat4_pre", 32'h1, 2);
      wr(DutyAddr, 32'h0303);
      expect_led("pat4_mid", 32'hEE, 8);
      wr(DutyAddr, 32'h0301);
      expect_led("pat4_wrap", 32'h17, 8);

      // Edge cases: duty 0, duty > period, inversion, disable
      wr(CtrlAddr, 32'h0);
      wr(DutyAddr, 32'h0300);
      wr(CtrlAddr, 32'h1);
      expect_led("duty0", 32'h0, 8);
      wr(CtrlAddr, 32'h0);
      wr(DutyAddr, 32'h0305);
      wr(CtrlAddr, 32'h1);
      expect_led("duty_gt_per", 32'hFF, 8);
      wr(CtrlAddr, 32'h3);
      expect_led("inv_full", 32'h0, 8);
      wr(CtrlAddr, 32'h0);
      wr(DutyAddr, 32'h0300);
      wr(CtrlAddr, 32'h3);
      expect_led("inv_duty0", 32'hFF, 8);
      wr(CtrlAddr, 32'h2);
      expect_led("dis_inv", 32'h0, 8);

      // Immediate set/clear and reset mid-period
      wr(CtrlAddr, 32'h3);
      cyc(1'b0, 1'b1, CtrlAddr, OpRci, 32'hFFFF_FFFF, 5'd1, rd);
      check("rci_old", rd, 32'h3);
      cyc(1'b0, 1'b1, CtrlAddr, OpRs, 32'd0, 5'd0, rd);
      check("rci_new", rd, 32'h2);
      expect_led("rci_led", 32'h0, 4);
      cyc(1'b0, 1'b1, CtrlAddr, OpRsi, 32'd0, 5'd1, rd);
      check("rsi_old", rd, 32'h2);
      wr(DutyAddr, 32'h0301);
      idle(5);
      cyc(1'b1, 1'b1, DutyAddr, OpRw, 32'h0505, 5'd0, rd);
      cyc(1'b0, 1'b1, CtrlAddr, OpRs, 32'd0, 5'd0, rd);
      check("ctrl_post_rst", rd, 32'd0);
      cyc(1'b0, 1'b1, DutyAddr, OpRs, 32'd0, 5'd0, rd);
      check("duty_post_rst", rd, 32'd0);
      expect_led("led_post_rst", 32'h0, 6);
      wr(DutyAddr, 32'h0301);
      wr(CtrlAddr, 32'h1);
      expect_led("pat_after_rst", 32'h11, 8);

      // Randomized traffic; prescale never changes while the counter keeps running
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 99);
         r   = $urandom;
         z   = 5'($urandom);
         op  = ops[$urandom_range(0, 5)];
         if (sel < 2) begin
            cyc(1'b1, r[0], DutyAddr, OpRw, r, z, rd);
         end else if (sel < 40) begin
            cyc(1'b0, 1'b0, r[1] ? CtrlAddr : DutyAddr, OpRw, r, z, rd);
         end else if (sel < 60) begin
            v = r & 32'hFFFF_070F;
            cyc(1'b0, 1'b1, DutyAddr, op, v, z, rd);
         end else if (sel < 75) begin
            v = r & 32'hFFFF_03FF;
            if (v[0] && m_en != 0) v[15:8] = 8'(m_prescale);
            cyc(1'b0, 1'b1, CtrlAddr, OpRw, v, z, rd);
         end else if (sel < 90) begin
            cyc(1'b0, 1'b1, CtrlAddr, r[1] ? OpRsi : OpRci, r, z, rd);
         end else begin
            cyc(1'b0, 1'b1, others[r[3:2]], op, r, z, rd);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
